// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with start-bit glitch rejection and framing check, feeding a
// first-word-fall-through receive FIFO. Define UART_RX_PARITY_EN to add a parity bit per frame.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_W     = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        RX,
  input  logic [BAUD_W-1:0]           baud_div,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rdy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        frm_err,
  output logic                        ovr_err
`ifdef UART_RX_PARITY_EN
  ,
  input  logic                        par_odd,
  output logic                        par_err
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_ONE = BAUD_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t               state_q, state_d;
  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s;
  logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d, div_q, div_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 frm_err_q, frm_err_d, ovr_err_q, ovr_err_d;
  logic                 expiry, frame_done, stop_ok, parity_ok, good_frame, frm_evt;
  logic                 push, pop, full, ovr_evt;
`ifdef UART_RX_PARITY_EN
  logic                 par_odd_q, par_odd_d, par_bit_q, par_bit_d, par_err_q, par_err_d;
  assign parity_ok = (((^shift_q) ^ par_bit_q) == par_odd_q);
`else
  assign parity_ok = 1'b1;
`endif

  assign rx_s   = rx_s2_q;
  assign expiry = (baud_cnt_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (expiry) state_d = rx_s ? IDLE : DATA;
      DATA:    if (expiry && idx_q == LAST_IDX) state_d = AFTER_DATA;
      PARITY:  if (expiry) state_d = STOP;
      STOP:    if (expiry) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state datapath and frame-completion outputs
  always_comb begin
    rx_s1_d    = RX;
    rx_s2_d    = rx_s1_q;
    baud_cnt_d = expiry ? (div_q - BAUD_ONE) : (baud_cnt_q - BAUD_ONE);
    div_d      = div_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    stop_ok    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_odd_d  = par_odd_q;
    par_bit_d  = par_bit_q;
`endif
    case (state_q)
      IDLE: begin
        // Divisor/half-bit load track the inputs while idle; last value is kept at frame start.
        baud_cnt_d = (baud_div >> 1) - BAUD_ONE;
        div_d      = baud_div;
        idx_d      = '0;
`ifdef UART_RX_PARITY_EN
        par_odd_d  = par_odd;
`endif
      end
      DATA: begin
        if (expiry) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_ONE;
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (expiry) par_bit_d = rx_s;
`endif
      end
      STOP: begin
        frame_done = expiry;
        stop_ok    = rx_s;
      end
      default: ;
    endcase
  end

  assign good_frame = frame_done & stop_ok & parity_ok;
  assign frm_evt    = frame_done & ~stop_ok;

  always_comb begin
    pop      = rd_en & rdy;
    full     = (cnt_q == FULL_CNT);
    push     = good_frame & (~full | pop);
    ovr_evt  = good_frame & full & ~pop;
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
    frm_err_d = (frm_err_q & ~clr_err) | frm_evt;
    ovr_err_d = (ovr_err_q & ~clr_err) | ovr_evt;
`ifdef UART_RX_PARITY_EN
    par_err_d = (par_err_q & ~clr_err) | (frame_done & stop_ok & ~parity_ok);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      baud_cnt_q <= '0;
      idx_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      frm_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      baud_cnt_q <= baud_cnt_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      frm_err_q  <= frm_err_d;
      ovr_err_q  <= ovr_err_d;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  // Data-only storage; validity is tracked by the reset control state above.
  always_ff @(posedge clk) begin
    div_q   <= div_d;
    shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
    par_odd_q <= par_odd_d;
    par_bit_q <= par_bit_d;
`endif
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rdy      = (cnt_q != '0);
  assign fifo_cnt = cnt_q;
  assign rx_data  = rdy ? mem_q[rd_ptr_q] : '0;
  assign frm_err  = frm_err_q;
  assign ovr_err  = ovr_err_q;
`ifdef UART_RX_PARITY_EN
  assign par_err  = par_err_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo (DATA_BITS=8, FIFO_DEPTH=4): vector table, hand-written corner
// sequences and randomized frame bursts against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int BW    = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          RX = 1'b1;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [BW-1:0] baud_div = BW'(16);
  logic [DB-1:0] rx_data;
  logic          rdy;
  logic [2:0]    fifo_cnt;
  logic          frm_err, ovr_err;
`ifdef UART_RX_PARITY_EN
  logic          par_odd = 1'b0;
  logic          par_err;
  logic          par_flip = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int bdiv = 16;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic [2:0] exp_cnt;
    logic       exp_frm;
  } vec_t;
  vec_t tbl[6];

  uart_rx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .BAUD_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .baud_div(baud_div), .rd_en(rd_en),
    .clr_err(clr_err), .rx_data(rx_data), .rdy(rdy), .fifo_cnt(fifo_cnt),
    .frm_err(frm_err), .ovr_err(ovr_err)
`ifdef UART_RX_PARITY_EN
    , .par_odd(par_odd), .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_rdy"}, rdy, 1);
    check(name, rx_data, exp);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  // RX sync adds 2 clocks and the stop sample lands h clocks after that, so with the stop bit
  // driven just after edge S the push edge is S+h+3 and rdy is first seen after it.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit do_pop, input bit chk_lat);
    int h;
    h = bdiv / 2;
    baud_div = BW'(bdiv);
    RX = 1'b0;
    tick(bdiv);
    for (int i = 0; i < DB; i++) begin
      RX = d[i];
      tick(bdiv);
    end
`ifdef UART_RX_PARITY_EN
    RX = (^d) ^ par_odd ^ par_flip;
    tick(bdiv);
`endif
    RX = stop;
    tick(h + 2);
    if (chk_lat) check("rdy_before_stop_sample", rdy, 0);
    if (do_pop) rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    if (chk_lat) check("rdy_one_clk_after_stop_sample", rdy, 1);
    if (bdiv - h - 3 > 0) tick(bdiv - h - 3);
    RX = 1'b1;
  endtask

  initial begin
    logic [7:0] mq[$];
    logic [7:0] d;
    bit         mfrm, movr, good;
    int         n;

    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 3'd1, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[2] = '{8'h00, 1'b1, 8'h00, 3'd1, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 8'hFF, 3'd1, 1'b0};
    tbl[4] = '{8'h55, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[5] = '{8'h80, 1'b1, 8'h80, 3'd1, 1'b0};

    rst_n = 1'b0;
    tick(2);
    check("reset_rdy", rdy, 0);
    check("reset_cnt", fifo_cnt, 0);
    check("reset_data", rx_data, 0);
    check("reset_frm", frm_err, 0);
    check("reset_ovr", ovr_err, 0);
    rst_n = 1'b1;
    tick(4);

    // Single 0xA5 frame, latency and pop
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    tick(2);
    check("a5_data", rx_data, 8'hA5);
    check("a5_cnt", fifo_cnt, 1);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("a5_pop_rdy", rdy, 0);
    check("a5_pop_cnt", fifo_cnt, 0);

    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("empty_pop_cnt", fifo_cnt, 0);
    check("empty_pop_rdy", rdy, 0);

    // Short start glitch
    RX = 1'b0;
    tick(5);
    RX = 1'b1;
    tick(3 * bdiv);
    check("glitch_rdy", rdy, 0);
    check("glitch_frm", frm_err, 0);
    check("glitch_ovr", ovr_err, 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, 1'b0, 1'b0);
      tick(bdiv);
      check("tbl_cnt", fifo_cnt, tbl[i].exp_cnt);
      check("tbl_data", rx_data, tbl[i].exp_data);
      check("tbl_frm", frm_err, tbl[i].exp_frm);
      if (tbl[i].exp_cnt != 0) pop_check("tbl_pop", tbl[i].exp_data);
      pulse_clr();
      check("tbl_clr_frm", frm_err, 0);
    end

    // Overrun: five back-to-back frames, no reads
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    tick(bdiv);
    check("ovr_cnt", fifo_cnt, 4);
    check("ovr_flag", ovr_err, 1);
    for (int i = 1; i <= 4; i++) pop_check("ovr_pop", 8'(i));
    check("ovr_drained_rdy", rdy, 0);
    pulse_clr();
    check("ovr_clr", ovr_err, 0);

    // Full FIFO with a pop on the fifth frame's push edge
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    send_frame(8'h05, 1'b1, 1'b1, 1'b0);
    tick(bdiv);
    check("fullpop_ovr", ovr_err, 0);
    check("fullpop_cnt", fifo_cnt, 4);
    for (int i = 2; i <= 5; i++) pop_check("fullpop_pop", 8'(i));
    check("fullpop_rdy", rdy, 0);

    // Reset during data bit 3 of 0xFF, with a queued frame and a framing error pending
    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    tick(bdiv);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    tick(bdiv);
    check("prereset_cnt", fifo_cnt, 1);
    check("prereset_frm", frm_err, 1);
    RX = 1'b0;
    tick(bdiv);
    RX = 1'b1;
    tick(3 * bdiv + bdiv / 2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("midreset_rdy", rdy, 0);
    check("midreset_cnt", fifo_cnt, 0);
    check("midreset_data", rx_data, 0);
    check("midreset_frm", frm_err, 0);
    check("midreset_ovr", ovr_err, 0);
    tick(6 * bdiv);
    check("postreset_idle_cnt", fifo_cnt, 0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    tick(bdiv);
    check("postreset_cnt", fifo_cnt, 1);
    pop_check("postreset_data", 8'h81);

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    par_flip = 1'b0;
    tick(bdiv);
    check("par_err", par_err, 1);
    check("par_cnt", fifo_cnt, 0);
    check("par_frm", frm_err, 0);
    pulse_clr();
    check("par_clr", par_err, 0);
`endif

    // Randomized bursts against a queue model
    for (int it = 0; it < 20; it++) begin
      bdiv = $urandom_range(4, 16);
      n = $urandom_range(1, 6);
      mq.delete();
      mfrm = 1'b0;
      movr = 1'b0;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        good = ($urandom_range(0, 7) != 0);
        if (!good) mfrm = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(d);
        else movr = 1'b1;
        send_frame(d, good, 1'b0, 1'b0);
        if (!good) tick(2 * bdiv);
      end
      tick(2 * bdiv);
      check("rand_cnt", fifo_cnt, mq.size());
      check("rand_frm", frm_err, mfrm);
      check("rand_ovr", ovr_err, movr);
      while (mq.size() > 0) pop_check("rand_pop", mq.pop_front());
      check("rand_empty", rdy, 0);
      pulse_clr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver for the serial link front end.
- Runtime-programmable baud divisor and parametrised data width.
- Start-bit glitch rejection and framing-error detection.
- Receive FIFO with overrun detection, so the command/host logic can drain bursts of back-to-back frames at its own pace.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >=2
BAUD_W, 12, width of baud_div input

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
RX  in  1  asynchronous serial input, idle high
baud_div  in  BAUD_W  clocks per bit; legal >=4; sampled at each frame start
rd_en  in  1  pop FIFO head; ignored when rdy=0
clr_err  in  1  clears frm_err and ovr_err
rx_data  out  DATA_BITS  FIFO head (first-word fall-through); valid when rdy=1
rdy  out  1  FIFO not empty
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
frm_err  out  1  sticky: stop bit sampled low
ovr_err  out  1  sticky: frame completed while FIFO full

Behaviour:
- Reset (rst_n low at posedge clk): state=IDLE; FIFO empty; rdy=0, fifo_cnt=0, rx_data=0, frm_err=0, ovr_err=0. Both RX sync flops reset to 1.
- RX passes through two flops (RX_s) before any use.
- Baud counter: down-counter. Expiry = counter==0, which reloads it. Full-bit load = baud_div-1 (period baud_div clocks). Half-bit load = (baud_div>>1)-1.
- baud_div is latched into an internal register on IDLE->START. Changes mid-frame have no effect.
- FSM states are IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
  - IDLE: RX_s==0 -> START, half-bit load.
  - START, on expiry: RX_s==1 -> IDLE (false start, nothing recorded). RX_s==0 -> DATA, full-bit load, bit index=0.
  - DATA, on each expiry: shift RX_s in LSB first and increment the bit index. After DATA_BITS samples -> STOP (or PARITY), full-bit load.
  - STOP, on expiry: sample RX_s.
    - 1: frame is good; push it.
    - 0: set frm_err, discard frame.
    - Either way -> IDLE the same cycle. The FSM re-arms mid-stop-bit, so a start bit immediately after the stop bit is caught.
- Push timing: the FIFO write occurs on the clock edge that samples the stop bit. rdy/fifo_cnt reflect it the following cycle. Latency from the stop-bit sample point to rdy=1 is 1 clock.
- FIFO: pointer-based circular buffer. Pointers wrap modulo FIFO_DEPTH; occupancy counts 0..FIFO_DEPTH.
  - rx_data always shows the oldest entry.
  - Pop when rd_en && rdy.
  - Push when the FIFO is full and no pop that cycle: frame dropped, ovr_err set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overrun.
  - Push and pop in the same cycle otherwise: both succeed, count unchanged.
  - rd_en while empty: no effect; count never underflows.
- Error flags: sticky until clr_err. If clr_err and a new error event occur in the same cycle, the flag ends up set.
- Reset asserted mid-frame aborts the frame: no push, FSM to IDLE, FIFO flushed.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - Adds input par_odd (1 = odd, 0 = even parity; latched at frame start).
  - Adds sticky output par_err, reset 0, cleared by clr_err.
  - Adds state PARITY between DATA and STOP, one full-bit period.
  - At STOP expiry with stop=1, a frame whose parity mismatches is discarded and sets par_err.
  - frm_err takes precedence: stop=0 sets only frm_err.
- Undefined: no PARITY state, no par_odd/par_err ports; frame = start + DATA_BITS + stop.

Test Plan:
1. baud_div=16, DATA_BITS=8: send 0xA5 (8N1) -> rdy=1 exactly 1 clk after stop-bit midpoint; rx_data=0xA5; fifo_cnt=1; rd_en 1 clk -> rdy=0, fifo_cnt=0.
2. RX low pulse of 5 clocks (< baud_div/2=8), then idle -> returns to IDLE, rdy stays 0, no error flags.
3. Send 0x3C with stop bit driven 0 -> frm_err=1, fifo_cnt=0. Assert clr_err -> frm_err=0 next cycle.
4. FIFO_DEPTH=4: send 0x01..0x05 back-to-back with no reads -> fifo_cnt=4, ovr_err=1. Pops return 0x01,0x02,0x03,0x04, then rdy=0.
5. FIFO full, rd_en held high across 5th frame's stop sample -> no ovr_err, fifo_cnt stays 4, tail = 0x05.
6. rst_n low for 1 clk during DATA bit 3 of 0xFF -> all outputs at reset values; next full frame 0x81 received correctly. With UART_RX_PARITY_EN, par_odd=0, send 0x81 with parity bit 1 -> par_err=1, no push.
